// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, debouncer and press/release
// pulse generator with optional auto-repeat, for N_CH push-buttons.
//
// Ports:
//   Clk      system clock, all state updates on the rising edge
//   Reset    synchronous, active-high reset
//   Btn_in   raw asynchronous button inputs (polarity set by ACTIVE_LOW)
//   Level    debounced button state, 1 = pressed
//   Press    one-cycle pulse on debounced press and on each auto-repeat
//   Release  one-cycle pulse on debounced release
module button_conditioner #(
    parameter int N_CH            = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] Btn_in,
    output logic [N_CH-1:0] Level,
    output logic [N_CH-1:0] Press,
    output logic [N_CH-1:0] Release
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    // Keep the repeat counter at least one bit wide even when repeat is off.
    localparam int RMAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0]   DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]   RPT_LAST = RW'(RMAX - 1);
    localparam bit              RPT_EN   = (REPEAT_CYCLES > 0);
    localparam logic [N_CH-1:0] IDLE     = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [N_CH-1:0][RW-1:0]          rpt_q, rpt_d;
    logic [N_CH-1:0]                  level_q, level_d;
    logic [N_CH-1:0]                  press_q, press_d;
    logic [N_CH-1:0]                  release_q, release_d;
    logic [N_CH-1:0]                  pressed;

    // Normalised synchroniser output: 1 = pressed, whatever the board polarity.
    assign pressed = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1]
                                       :  sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], Btn_in};
        level_d   = level_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            // Any sample agreeing with Level restarts the debounce window.
            if (pressed[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = pressed[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            press_d[i]   =  level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] &  level_q[i];

            // Repeat runs only across edges where the key stays held, so the
            // press edge and the release edge both clear it and a release
            // edge can never carry a repeat pulse.
            if (RPT_EN && level_q[i] && level_d[i]) begin
                if (rpt_q[i] == RPT_LAST) begin
                    rpt_d[i]   = '0;
                    press_d[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + 1'b1;
                end
            end else begin
                rpt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q    <= {SYNC_STAGES{IDLE}};
            cnt_q     <= '0;
            rpt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign Level   = level_q;
    assign Press   = press_q;
    assign Release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of button_conditioner with default
// parameters (instance a) and with auto-repeat of 5 cycles (instance b).
module tb_button_conditioner;

    logic       Clk;
    logic       Reset;
    logic [2:0] btn_a, lvl_a, prs_a, rel_a;
    logic [2:0] btn_b, lvl_b, prs_b, rel_b;

    int n_cmp;
    int n_err;

    button_conditioner u_a (
        .Clk     (Clk),
        .Reset   (Reset),
        .Btn_in  (btn_a),
        .Level   (lvl_a),
        .Press   (prs_a),
        .Release (rel_a)
    );

    button_conditioner #(
        .REPEAT_CYCLES (5)
    ) u_b (
        .Clk     (Clk),
        .Reset   (Reset),
        .Btn_in  (btn_b),
        .Level   (lvl_b),
        .Press   (prs_b),
        .Release (rel_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [2:0] btn;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic rst, logic [2:0] b,
                                logic [2:0] l, logic [2:0] p,
                                logic [2:0] r);
        vec_t v;
        v.rst = rst;
        v.btn = b;
        v.lvl = l;
        v.prs = p;
        v.rel = r;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(string name, int idx, logic [2:0] act,
                       logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        btn_a = 3'b111;
        btn_b = 3'b111;

        // Vector i is applied before edge i; outputs checked just after it.
        add(2, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        add(3, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        add(2, 1'b0, 3'b110, 3'b000, 3'b000, 3'b000);
        add(3, 1'b0, 3'b010, 3'b000, 3'b000, 3'b000);
        add(1, 1'b0, 3'b010, 3'b001, 3'b001, 3'b000);
        add(1, 1'b0, 3'b010, 3'b001, 3'b000, 3'b000);
        add(1, 1'b0, 3'b010, 3'b101, 3'b100, 3'b000);
        add(2, 1'b0, 3'b010, 3'b101, 3'b000, 3'b000);
        add(3, 1'b0, 3'b000, 3'b101, 3'b000, 3'b000);
        add(5, 1'b0, 3'b010, 3'b101, 3'b000, 3'b000);
        add(5, 1'b0, 3'b111, 3'b101, 3'b000, 3'b000);
        add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b101);
        add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);

        foreach (tbl[i]) begin
            Reset = tbl[i].rst;
            btn_a = tbl[i].btn;
            tick();
            chk("tbl_level", i, lvl_a, tbl[i].lvl);
            chk("tbl_press", i, prs_a, tbl[i].prs);
            chk("tbl_release", i, rel_a, tbl[i].rel);
        end

        // Reset one edge while ch1 is held with its debounce count at 2.
        for (int k = 0; k < 13; k++) begin
            Reset = (k == 4);
            btn_a = 3'b101;
            tick();
            chk("rst_level", k, lvl_a, (k >= 10) ? 3'b010 : 3'b000);
            chk("rst_press", k, prs_a, (k == 10) ? 3'b010 : 3'b000);
            chk("rst_release", k, rel_a, 3'b000);
        end
        Reset = 1'b0;
        btn_a = 3'b111;

        // Auto-repeat: Level falls on the edge where a repeat would be due.
        for (int k = 0; k < 35; k++) begin
            btn_b = (k < 25) ? 3'b110 : 3'b111;
            tick();
            chk("rpt_level", k, lvl_b,
                {2'b00, (k >= 5 && k < 30)});
            chk("rpt_press", k, prs_b,
                {2'b00, (k >= 5 && k <= 25 && (k % 5) == 0)});
            chk("rpt_release", k, rel_b, {2'b00, (k == 30)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
